// File: rtl/vector_op_sequencer_if.sv
// Element issue/response channel between the vector sequencer and the
// shared scalar ALU/memory path.
//   master (sequencer): drives elem_valid/elem_idx/elem_addr/elem_op,
//                       samples elem_ready/resp_valid
//   slave  (datapath) : the reverse
`timescale 1ns/1ps
interface vector_op_sequencer_if #(
  parameter int unsigned IDX_W = 4
) ();
  logic             elem_valid;
  logic             elem_ready;
  logic [IDX_W-1:0] elem_idx;
  logic [31:0]      elem_addr;
  logic [2:0]       elem_op;
  logic             resp_valid;

  modport master (
    output elem_valid, elem_idx, elem_addr, elem_op,
    input  elem_ready, resp_valid
  );

  modport slave (
    input  elem_valid, elem_idx, elem_addr, elem_op,
    output elem_ready, resp_valid
  );
endinterface

// File: rtl/vector_op_sequencer.sv
// Multi-cycle sequencer for vector instructions leaving decode. Latches op,
// base address and length on start, issues one element per handshake, and
// stalls fetch/decode until every issued element has responded.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   VecStartD             vector instruction valid in decode
//   ALUControlD/BaseAddr/VecLen  op, element-0 address, length (latched at start)
//   Stuck                 halt request, freezes starts and issue
//   elem                  issue/response channel (master side)
//   StallF/StallD         fetch/decode stall
//   VecDone               one-cycle completion pulse
//   busy                  sequencer not idle
//   err                   sticky: response seen with nothing in flight
`timescale 1ns/1ps
module vector_op_sequencer #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned STRIDE  = 4,
  localparam int unsigned IDX_W  = $clog2(MAX_LEN),
  localparam int unsigned LEN_W  = IDX_W + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 VecStartD,
  input  logic [2:0]           ALUControlD,
  input  logic [31:0]          BaseAddr,
  input  logic [LEN_W-1:0]     VecLen,
  input  logic                 Stuck,
  vector_op_sequencer_if.master elem,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 VecDone,
  output logic                 busy,
  output logic                 err
);
  localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [2:0]       op_q, op_d;
  logic [31:0]      base_q, base_d;
  logic [OUT_W-1:0] inflight_q, inflight_d;
  logic             err_q, err_d;

  logic             valid, hs, stall, done, resp_ok;
  logic [LEN_W-1:0] len_clamp;

  // State and latches
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      len_q      <= '0;
      op_q       <= '0;
      base_q     <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      op_q       <= op_d;
      base_q     <= base_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  // Next state, counters and handshake outputs
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    len_d      = len_q;
    op_d       = op_q;
    base_d     = base_q;
    inflight_d = inflight_q;
    err_d      = err_q;
    valid      = 1'b0;
    hs         = 1'b0;
    stall      = 1'b0;
    done       = 1'b0;
    len_clamp  = (VecLen > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : VecLen;
    // A response with nothing outstanding is flagged and otherwise dropped.
    resp_ok    = elem.resp_valid && (inflight_q != '0);

    case (state_q)
      IDLE: begin
        if (VecStartD && !Stuck) begin
          stall   = 1'b1;
          len_d   = len_clamp;
          op_d    = ALUControlD;
          base_d  = BaseAddr;
          idx_d   = '0;
          state_d = (len_clamp == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        stall = 1'b1;
        valid = !Stuck && (inflight_q < OUT_W'(MAX_OUT));
        hs    = valid && elem.elem_ready;
        if (hs) begin
          idx_d = idx_q + LEN_W'(1);
          if (idx_q == len_q - LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        stall = 1'b1;
        // Leave as soon as the last outstanding response lands.
        if ((inflight_q == '0) || ((inflight_q == OUT_W'(1)) && resp_ok))
          state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (hs && !resp_ok)      inflight_d = inflight_q + OUT_W'(1);
    else if (!hs && resp_ok) inflight_d = inflight_q - OUT_W'(1);

    if (elem.resp_valid && (inflight_q == '0)) err_d = 1'b1;
  end

  assign elem.elem_valid = valid;
  assign elem.elem_idx   = idx_q[IDX_W-1:0];
  assign elem.elem_addr  = base_q + (32'(idx_q) * 32'(STRIDE));
  assign elem.elem_op    = op_q;
  assign StallF          = stall;
  assign StallD          = stall;
  assign VecDone         = done;
  assign busy            = (state_q != IDLE);
  assign err             = err_q;
endmodule

// File: tb/tb_vector_op_sequencer.sv
`timescale 1ns/1ps
module tb_vector_op_sequencer;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned LEN_W = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             VecStartD;
  logic [2:0]       ALUControlD;
  logic [31:0]      BaseAddr;
  logic [LEN_W-1:0] VecLen;
  logic             Stuck;
  logic             StallF, StallD, VecDone, busy, err;

  vector_op_sequencer_if #(.IDX_W(IDX_W)) vif ();

  vector_op_sequencer #(.MAX_LEN(16), .MAX_OUT(4), .STRIDE(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .VecStartD   (VecStartD),
    .ALUControlD (ALUControlD),
    .BaseAddr    (BaseAddr),
    .VecLen      (VecLen),
    .Stuck       (Stuck),
    .elem        (vif),
    .StallF      (StallF),
    .StallD      (StallD),
    .VecDone     (VecDone),
    .busy        (busy),
    .err         (err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Responder / scoreboard state
  int          pending, issued, done_cnt, done_at, cyc_cnt;
  bit          resp_en;
  logic [31:0] exp_base;
  logic [2:0]  exp_op;
  logic        s_valid;
  logic [3:0]  s_idx;
  logic [31:0] s_addr;
  logic [2:0]  s_op;

  typedef struct {
    logic [2:0]       op;
    logic [31:0]      base;
    logic [LEN_W-1:0] len;
    int               exp_issues;
    int               exp_lat;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // One clock cycle, entered and left at posedge+1. Responses come back one
  // per cycle for each outstanding element while resp_en is set.
  task automatic step_cycle();
    logic hs;
    vif.resp_valid = resp_en && (pending > 0);
    #1;
    cyc_cnt++;
    hs      = vif.elem_valid && vif.elem_ready;
    s_valid = vif.elem_valid;
    s_idx   = vif.elem_idx;
    s_addr  = vif.elem_addr;
    s_op    = vif.elem_op;
    if (hs) begin
      check("elem_idx", 32'(vif.elem_idx), 32'(issued));
      check("elem_addr", vif.elem_addr, exp_base + 32'(issued) * 32'd4);
      check("elem_op", 32'(vif.elem_op), 32'(exp_op));
      issued++;
    end
    if (VecDone) begin
      done_cnt++;
      done_at = cyc_cnt;
      check("stall_in_done", 32'({StallF, StallD}), 32'd0);
    end
    if (vif.resp_valid) pending--;
    if (hs) pending++;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [2:0] op, input logic [31:0] base, input logic [LEN_W-1:0] len);
    VecStartD      = 1'b1;
    ALUControlD    = op;
    BaseAddr       = base;
    VecLen         = len;
    vif.resp_valid = 1'b0;
    exp_base = base;
    exp_op   = op;
    issued   = 0;
    done_cnt = 0;
    done_at  = -1;
    cyc_cnt  = 0;
    #1;
    check("accept_stall", 32'({StallF, StallD}), 32'd3);
    check("accept_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    // Scramble decode inputs to prove the sequencer uses its latched copies.
    VecStartD   = 1'b0;
    ALUControlD = ~op;
    BaseAddr    = 32'hDEAD_0000;
    VecLen      = 5'd7;
  endtask

  task automatic run_until_done(input int bound);
    for (int i = 0; i < bound && done_cnt == 0; i++) step_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; VecStartD = 1'b0; ALUControlD = '0; BaseAddr = '0; VecLen = '0;
    Stuck = 1'b0; vif.elem_ready = 1'b0; vif.resp_valid = 1'b0;
    pending = 0; resp_en = 1'b1; issued = 0; done_cnt = 0; done_at = -1; cyc_cnt = 0;
    exp_base = '0; exp_op = '0;

    tbl[0] = '{3'b000, 32'h0000_0100, 5'd4,  4,  6};
    tbl[1] = '{3'b111, 32'h0000_0000, 5'd0,  0,  1};
    tbl[2] = '{3'b101, 32'hFFFF_FFF8, 5'd4,  4,  6};
    tbl[3] = '{3'b010, 32'h0000_2000, 5'd1,  1,  3};
    tbl[4] = '{3'b110, 32'h0000_0040, 5'd20, 16, 18};
    tbl[5] = '{3'b001, 32'h0000_0010, 5'd16, 16, 18};

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(vif.elem_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stall", 32'({StallF, StallD}), 32'd0);
    check("rst_done_err", 32'({VecDone, err}), 32'd0);
    reset = 1'b0;

    // Straight-through vectors: ready always high, 1-cycle responses
    for (int t = 0; t < 6; t++) begin
      resp_en = 1'b1; vif.elem_ready = 1'b1; Stuck = 1'b0;
      start(tbl[t].op, tbl[t].base, tbl[t].len);
      run_until_done(60);
      check("tbl_issues", 32'(issued), 32'(tbl[t].exp_issues));
      check("tbl_done_cycle", 32'(done_at), 32'(tbl[t].exp_lat));
      check("tbl_idle_after", 32'({busy, VecDone, StallF}), 32'd0);
      check("tbl_err", 32'(err), 32'd0);
    end

    // In-flight limit: withheld responses cap issue at four
    resp_en = 1'b0; vif.elem_ready = 1'b1;
    start(3'b001, 32'h0000_3000, 5'd8);
    repeat (8) step_cycle();
    check("cap_issued", 32'(issued), 32'd4);
    check("cap_valid_low", 32'(vif.elem_valid), 32'd0);
    check("cap_busy", 32'(busy), 32'd1);
    resp_en = 1'b1;
    run_until_done(40);
    check("cap_issued_total", 32'(issued), 32'd8);
    check("cap_done", 32'(done_cnt), 32'd1);
    check("cap_err", 32'(err), 32'd0);

    // Backpressure on element 1; a new start during the hold is ignored
    resp_en = 1'b1;
    start(3'b010, 32'h0000_0500, 5'd3);
    step_cycle();
    vif.elem_ready = 1'b0;
    VecStartD = 1'b1; BaseAddr = 32'h0000_9000; ALUControlD = 3'b111; VecLen = 5'd9;
    for (int i = 0; i < 5; i++) begin
      step_cycle();
      check("hold_valid", 32'(s_valid), 32'd1);
      check("hold_idx", 32'(s_idx), 32'd1);
      check("hold_addr", s_addr, 32'h0000_0504);
      check("hold_op", 32'(s_op), 32'd2);
    end
    VecStartD = 1'b0;
    vif.elem_ready = 1'b1;
    run_until_done(20);
    check("hold_issued", 32'(issued), 32'd3);
    repeat (3) step_cycle();
    check("hold_single_done", 32'(done_cnt), 32'd1);

    // Stuck freezes issue at idx2 while responses keep draining
    start(3'b011, 32'h0000_0800, 5'd6);
    step_cycle();
    step_cycle();
    Stuck = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step_cycle();
      check("stuck_valid", 32'(s_valid), 32'd0);
    end
    check("stuck_issued", 32'(issued), 32'd2);
    check("stuck_stall", 32'({busy, StallF}), 32'd3);
    Stuck = 1'b0;
    step_cycle();
    check("stuck_resume_valid", 32'(s_valid), 32'd1);
    check("stuck_resume_idx", 32'(s_idx), 32'd2);
    run_until_done(20);
    check("stuck_issued_total", 32'(issued), 32'd6);
    check("stuck_err", 32'(err), 32'd0);

    // Stuck also blocks a start in IDLE
    Stuck = 1'b1; VecStartD = 1'b1; VecLen = 5'd3;
    #1;
    check("stuck_start_stall", 32'(StallF), 32'd0);
    @(posedge clk);
    #1;
    check("stuck_start_busy", 32'(busy), 32'd0);
    VecStartD = 1'b0; Stuck = 1'b0;

    // Reset in DRAIN with two elements still in flight
    resp_en = 1'b0;
    start(3'b100, 32'h0000_0C00, 5'd4);
    repeat (4) step_cycle();
    resp_en = 1'b1;
    repeat (2) step_cycle();
    resp_en = 1'b0;
    check("drain_busy_stall", 32'({busy, StallF, vif.elem_valid}), 32'd6);
    reset = 1'b1; vif.resp_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rstd_ctrl", 32'({vif.elem_valid, busy, StallF, StallD, VecDone, err}), 32'd0);
    check("rstd_idx", 32'(vif.elem_idx), 32'd0);
    check("rstd_addr", vif.elem_addr, 32'd0);
    check("rstd_op", 32'(vif.elem_op), 32'd0);
    pending = 0;
    repeat (3) step_cycle();
    check("rstd_no_done", 32'(done_cnt), 32'd0);
    check("rstd_no_issue", 32'(issued), 32'd4);

    // Stray response with nothing in flight sets sticky err
    vif.resp_valid = 1'b1;
    @(posedge clk);
    #1;
    vif.resp_valid = 1'b0;
    check("err_set", 32'(err), 32'd1);
    repeat (2) step_cycle();
    check("err_sticky", 32'(err), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("err_cleared", 32'(err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
